// File: rtl/rca_op_sequencer.sv
// Sequential front-end for a WIDTH-bit ripple-carry adder: registers operands, waits
// SETTLE_CYCLES, captures sum/carry. Optional self-check enabled by RCA_SEQ_CHECK_EN.
module rca_op_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_chain,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy,
    output logic             err
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; valid
    // holds its payload stable until that edge, and ready never depends on valid.

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESULT} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
    logic             add_cin_q, add_cin_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_cout_q, out_cout_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             carry_q, carry_d;
    logic             capture;

    assign capture = (state_q == S_SETTLE) && (cnt_q == 4'(SETTLE_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        carry_d     = carry_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    add_a_d   = in_a;
                    add_b_d   = in_b;
                    add_cin_d = in_chain ? carry_q : in_cin;
                    cnt_d     = 4'd0;
                    busy_d    = 1'b1;
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (capture) begin
                    out_sum_d   = add_sum;
                    out_cout_d  = add_cout;
                    carry_d     = add_cout;
                    out_valid_d = 1'b1;
                    state_d     = S_RESULT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESULT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef RCA_SEQ_CHECK_EN
    logic [WIDTH:0] exp_full;
    logic           err_q, err_d;

    // Independent reference for the adder, checked only at the capture edge.
    always_comb begin
        exp_full = {1'b0, add_a_q} + {1'b0, add_b_q} + {{WIDTH{1'b0}}, add_cin_q};
        err_d    = err_q;
        if (capture && ({add_cout, add_sum} != exp_full))
            err_d = 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            carry_q     <= 1'b0;
`ifdef RCA_SEQ_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            carry_q     <= carry_d;
`ifdef RCA_SEQ_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_rca_op_sequencer.sv
// Directed bench for rca_op_sequencer with a behavioural 4-bit adder and sum override.
module tb_rca_op_sequencer;
  localparam int W = 4;
  localparam int SC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_cin = 1'b0, in_chain = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [W-1:0] add_a, add_b, add_sum, out_sum;
  logic add_cin, add_cout, in_ready, out_valid, out_cout, busy, err;

  logic ovr_en = 1'b0;
  logic [W-1:0] ovr_sum = '0;
  logic [W:0] adder_full;

  int n_checks = 0;
  int n_fail = 0;

  assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_sum  = ovr_en ? ovr_sum : adder_full[W-1:0];
  assign add_cout = adder_full[W];

  always #5 clk = ~clk;

  rca_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_chain(in_chain),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one operand pair, checks the driven adder inputs, the latency and the result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic chain, input logic exp_cin,
                      input logic [W-1:0] exp_sum, input logic exp_cout);
    int c;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_chain = chain;
    step();
    in_valid = 1'b0; in_a = 'x; in_b = 'x; in_cin = 1'b0; in_chain = 1'b0;
    chk("acc_add_a", 8'(add_a), 8'(a));
    chk("acc_add_cin", 8'(add_cin), 8'(exp_cin));
    chk("acc_busy", 8'(busy), 8'd1);
    c = 0;
    while (!out_valid && c < 20) begin
      step();
      c++;
    end
    chk("latency", 8'(c), 8'(SC));
    chk("out_sum", 8'(out_sum), 8'(exp_sum));
    chk("out_cout", 8'(out_cout), 8'(exp_cout));
  endtask

  logic exp_err;

  initial begin
`ifdef RCA_SEQ_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    // Reset state
    rst = 1'b1;
    step(); step();
    chk("rst_in_ready", 8'(in_ready), 8'd0);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_add_a", 8'(add_a), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_err", 8'(err), 8'd0);
    rst = 1'b0;
    step();
    chk("idle_in_ready", 8'(in_ready), 8'd1);

    // Basic add, output accepted immediately
    out_ready = 1'b1;
    send(4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0);
    chk("basic_in_ready_in_result", 8'(in_ready), 8'd0);
    step();
    chk("basic_out_valid_drop", 8'(out_valid), 8'd0);
    chk("basic_in_ready_back", 8'(in_ready), 8'd1);
    chk("basic_busy_drop", 8'(busy), 8'd0);

    // Overflow, then chained carry
    send(4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1);
    step();
    send(4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0);
    step();

    // Backpressure
    out_ready = 1'b0;
    send(4'd6, 4'd3, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; in_a = 4'(i + 10); in_b = 4'd1;
      step();
      chk("bp_in_ready", 8'(in_ready), 8'd0);
      chk("bp_out_valid", 8'(out_valid), 8'd1);
    end
    in_valid = 1'b0;
    chk("bp_out_sum", 8'(out_sum), 8'd9);
    chk("bp_out_cout", 8'(out_cout), 8'd0);
    chk("bp_add_a", 8'(add_a), 8'd6);
    chk("bp_add_b", 8'(add_b), 8'd3);
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", 8'(out_valid), 8'd0);
    chk("bp_release_ready", 8'(in_ready), 8'd1);
    chk("bp_add_a_hold", 8'(add_a), 8'd6);

    // Chain from reset: leave carry_q=1, then reset clears it
    send(4'd8, 4'd8, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(4'd2, 4'd2, 1'b1, 1'b1, 1'b0, 4'd4, 1'b0);
    step();

    // Reset mid-SETTLE with carry_q=1 beforehand
    send(4'd9, 4'd9, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1);
    step();
    in_valid = 1'b1; in_a = 4'd7; in_b = 4'd1; in_cin = 1'b0; in_chain = 1'b0;
    step();
    in_valid = 1'b0;
    chk("mid_accept_add_a", 8'(add_a), 8'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_add_a_cleared", 8'(add_a), 8'd0);
    chk("mid_busy_cleared", 8'(busy), 8'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_out_valid", 8'(out_valid), 8'd0);
    end
    send(4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
    step();

    // Corrupted adder sum: 2+4 should be 6, adder reports 4
    ovr_en = 1'b1; ovr_sum = 4'd4;
    send(4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0);
    ovr_en = 1'b0;
    chk("err_at_capture", 8'(err), 8'(exp_err));
    step();
    send(4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
    step();
    chk("err_sticky", 8'(err), 8'(exp_err));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_cleared", 8'(err), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
